// File: rtl/matmul_host_sequencer_if.sv
// matmul_host_sequencer_if: command, operand-row, engine, register-bus and result signals of the sequencer
interface matmul_host_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [15:0] cmd_ctrl_i;
  logic row_valid_i;
  logic row_ready_o;
  logic [BUS_WIDTH-1:0] row_data_i;
  logic done_i;
  logic [ADDR_WIDTH-1:0] address_o;
  logic [BUS_WIDTH-1:0] data_o;
  logic write_enable_o;
  logic [MAX_DIM-1:0] strobe_o;
  logic [BUS_WIDTH-1:0] data_i;
  logic res_valid_o;
  logic res_ready_i;
  logic [BUS_WIDTH-1:0] res_data_o;
  logic [BUS_WIDTH-1:0] flags_o;
  logic job_done_o;
  logic error_o;
  modport master (
    input cmd_valid_i, cmd_ctrl_i, row_valid_i, row_data_i, done_i, data_i, res_ready_i,
    output cmd_ready_o, row_ready_o, address_o, data_o, write_enable_o, strobe_o,
    output res_valid_o, res_data_o, flags_o, job_done_o, error_o
  );
  modport slave (
    output cmd_valid_i, cmd_ctrl_i, row_valid_i, row_data_i, done_i, data_i, res_ready_i,
    input cmd_ready_o, row_ready_o, address_o, data_o, write_enable_o, strobe_o,
    input res_valid_o, res_data_o, flags_o, job_done_o, error_o
  );
endinterface

// File: rtl/matmul_host_sequencer.sv
// matmul_host_sequencer: loads operand rows, starts the engine, then drains the scratchpad and FLAGS
module matmul_host_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 1024,
  parameter int START_BIT_POS = 0
) (
  input logic clk_i,
  input logic rst_i,
  matmul_host_sequencer_if.master bus
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NE = MAX_DIM * MAX_DIM;
  localparam int RW = $clog2(MAX_DIM + 1);
  localparam int EW = $clog2(NE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [4:0] CONTROL = 5'b00000;
  localparam logic [4:0] OPERAND_A = 5'b00100;
  localparam logic [4:0] OPERAND_B = 5'b01100;
  localparam logic [4:0] FLAGS = 5'b01000;
  localparam logic [4:0] SP = 5'b10000;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, READ_SP, READ_FLAGS} state_t;
  state_t state;
  logic [15:0] ctrl;
  logic [RW-1:0] row_cnt;
  logic [EW-1:0] elem;
  logic [TW-1:0] tmo;
  function automatic logic [ADDR_WIDTH-1:0] addr(input logic [4:0] op, input int unsigned idx);
    return (ADDR_WIDTH'(idx) << 5) | ADDR_WIDTH'(op);
  endfunction
  assign bus.cmd_ready_o = state == IDLE && !rst_i;
  assign bus.row_ready_o = state == LOAD_A || state == LOAD_B;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ctrl <= '0;
      row_cnt <= '0;
      elem <= '0;
      tmo <= '0;
      bus.address_o <= '0;
      bus.data_o <= '0;
      bus.write_enable_o <= 1'b0;
      bus.strobe_o <= '0;
      bus.res_valid_o <= 1'b0;
      bus.res_data_o <= '0;
      bus.flags_o <= '0;
      bus.job_done_o <= 1'b0;
      bus.error_o <= 1'b0;
    end else begin
      bus.write_enable_o <= 1'b0;
      bus.strobe_o <= '0;
      bus.job_done_o <= 1'b0;
      bus.error_o <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid_i) begin
          ctrl <= bus.cmd_ctrl_i;
          row_cnt <= '0;
          state <= LOAD_A;
        end
        LOAD_A, LOAD_B: if (bus.row_valid_i) begin
          bus.write_enable_o <= 1'b1;
          bus.strobe_o <= '1;
          bus.data_o <= bus.row_data_i;
          bus.address_o <= addr(state == LOAD_A ? OPERAND_A : OPERAND_B, 32'(row_cnt));
          row_cnt <= row_cnt + 1'b1;
          if (row_cnt == RW'(MAX_DIM - 1)) begin
            row_cnt <= '0;
            state <= state == LOAD_A ? LOAD_B : START;
          end
        end
        START: begin
          bus.write_enable_o <= 1'b1;
          bus.strobe_o <= '1;
          bus.address_o <= addr(CONTROL, 0);
          bus.data_o <= BUS_WIDTH'(ctrl | (16'd1 << START_BIT_POS));
          tmo <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: if (bus.done_i) begin
          elem <= '0;
          bus.address_o <= addr(SP, 0);
          state <= READ_SP;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          bus.job_done_o <= 1'b1;
          bus.error_o <= 1'b1;
          state <= IDLE;
        end else tmo <= tmo + 1'b1;
        // each element takes a capture edge then a handshake edge, so res_data_o never changes while offered
        READ_SP: if (!bus.res_valid_o) begin
          bus.res_data_o <= bus.data_i;
          bus.res_valid_o <= 1'b1;
        end else if (bus.res_ready_i) begin
          bus.res_valid_o <= 1'b0;
          elem <= elem + 1'b1;
          bus.address_o <= elem == EW'(NE - 1) ? addr(FLAGS, 0) : addr(SP, 32'(elem) + 32'd1);
          if (elem == EW'(NE - 1)) state <= READ_FLAGS;
        end
        READ_FLAGS: begin
          bus.flags_o <= bus.data_i;
          bus.job_done_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb_matmul_host_sequencer: directed job sequence with write/result scoreboards for matmul_host_sequencer
module tb_matmul_host_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  matmul_host_sequencer_if #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32)) bus ();
  matmul_host_sequencer #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(8), .START_BIT_POS(0))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction
  assign bus.data_i = mem(bus.address_o);
  typedef struct packed {logic [31:0] a; logic [63:0] d;} wr_t;
  wr_t wq[$];
  logic [63:0] rq[$];
  int wcyc[$];
  int tests = 0, fails = 0, cyc = 0, res_got = 0, jd_cnt = 0, jd_cyc = 0, ctrl_cyc = 0;
  int sp_reads = 0, hs_cnt = 0, low = 0;
  logic jd_err = 1'b0;
  logic p_stall = 1'b0;
  logic [63:0] p_data = '0;
  logic [31:0] p_addr = '0;
  logic [63:0] rows [4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                            64'hDEAD_BEEF_0000_0001, 64'h8000_0000_7FFF_FFFF};
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset_state();
    chk("reset_bus", {bus.address_o, bus.data_o, bus.write_enable_o, bus.strobe_o}, '0);
    chk("reset_result", {bus.res_valid_o, bus.res_data_o, bus.job_done_o, bus.error_o}, '0);
    chk("reset_flags", bus.flags_o, '0);
    chk("ready_in_reset", {bus.cmd_ready_o, bus.row_ready_o}, '0);
  endtask
  task automatic step();
    wr_t w;
    @(negedge clk);
    cyc++;
    if (bus.write_enable_o) begin
      wcyc.push_back(cyc);
      if (bus.address_o == 32'h0) ctrl_cyc = cyc;
      chk("write_pending", 128'(wq.size() > 0), 128'(1));
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("write", {bus.address_o, bus.data_o, bus.strobe_o}, {w.a, w.d, 2'b11});
      end
    end
    if (p_stall) chk("stall_hold", {bus.res_valid_o, bus.address_o, bus.res_data_o}, {1'b1, p_addr, p_data});
    p_stall = bus.res_valid_o && !bus.res_ready_i;
    p_addr = bus.address_o;
    p_data = bus.res_data_o;
    if (bus.res_valid_o && bus.res_ready_i) begin
      res_got++;
      chk("result_pending", 128'(rq.size() > 0), 128'(1));
      if (rq.size() > 0) chk("result_data", bus.res_data_o, rq.pop_front());
    end
    if (bus.address_o[4:0] == 5'h10) sp_reads++;
    chk("error_qualified", 128'(bus.error_o & ~bus.job_done_o), 128'(0));
    if (bus.job_done_o) begin
      jd_cnt++;
      jd_cyc = cyc;
      jd_err = bus.error_o;
    end
    if (bus.cmd_valid_i && bus.cmd_ready_o && !bus.job_done_o) hs_cnt++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_ctrl_i = '0;
    bus.row_valid_i = 1'b0;
    bus.row_data_i = '0;
    bus.done_i = 1'b0;
    bus.res_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    chk("row_ready_idle", bus.row_ready_o, 0);
    @(posedge clk);
    #1;
    // job 1: back-to-back operand writes, CONTROL write, SP drain with a stalled element, FLAGS
    wq.push_back({32'h04, rows[0]});
    wq.push_back({32'h24, rows[1]});
    wq.push_back({32'h0C, rows[2]});
    wq.push_back({32'h2C, rows[3]});
    wq.push_back({32'h00, 64'h0011});
    foreach (rows[i]) rq.push_back(mem(32'h10 + 32'(i) * 32'h20));
    bus.cmd_ctrl_i = 16'h0010;
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_valid_i = 1'b0;
    chk("row_ready_load_a", bus.row_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      bus.row_data_i = rows[i];
      bus.row_valid_i = 1'b1;
      step();
    end
    bus.row_valid_i = 1'b0;
    repeat (5) step();
    bus.done_i = 1'b1;
    step();
    bus.done_i = 1'b0;
    for (int i = 0; i < 60 && jd_cnt == 0; i++) begin
      step();
      bus.res_ready_i = !(res_got == 1 && bus.res_valid_o && low < 3);
      if (!bus.res_ready_i) low++;
    end
    bus.res_ready_i = 1'b1;
    chk("job1_done_count", jd_cnt, 1);
    chk("job1_error", jd_err, 0);
    chk("job1_flags", bus.flags_o, mem(32'h08));
    chk("job1_results", res_got, 4);
    chk("job1_stall_cycles", low, 3);
    chk("job1_writes_left", wq.size(), 0);
    chk("job1_results_left", rq.size(), 0);
    chk("job1_write_count", wcyc.size(), 5);
    for (int i = 0; i < 4 && i + 1 < wcyc.size(); i++) chk("write_spacing", wcyc[i+1] - wcyc[i], 1);
    // job 2: no done_i -> timeout abort; cmd_valid_i held high throughout
    jd_cnt = 0;
    sp_reads = 0;
    hs_cnt = 0;
    wcyc.delete();
    for (int i = 0; i < 2; i++) wq.push_back({32'h04 + 32'(i) * 32'h20, ~rows[i]});
    for (int i = 0; i < 2; i++) wq.push_back({32'h0C + 32'(i) * 32'h20, ~rows[i+2]});
    wq.push_back({32'h00, 64'h0A03});
    bus.cmd_ctrl_i = 16'h0A02;
    bus.cmd_valid_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.row_data_i = ~rows[i];
      bus.row_valid_i = 1'b1;
      step();
    end
    bus.row_valid_i = 1'b0;
    for (int i = 0; i < 40 && jd_cnt == 0; i++) step();
    bus.cmd_valid_i = 1'b0;
    chk("timeout_done_count", jd_cnt, 1);
    chk("timeout_error", jd_err, 1);
    chk("timeout_latency", jd_cyc - ctrl_cyc, 8);
    chk("timeout_no_sp_read", sp_reads, 0);
    chk("timeout_flags_kept", bus.flags_o, mem(32'h08));
    chk("single_job_while_busy", hs_cnt, 1);
    chk("job2_writes_left", wq.size(), 0);
    // job 3 was accepted from the held command; reset it during LOAD_B row 0
    wq.push_back({32'h04, rows[3]});
    wq.push_back({32'h24, rows[2]});
    for (int i = 0; i < 2; i++) begin
      bus.row_data_i = rows[3-i];
      bus.row_valid_i = 1'b1;
      step();
    end
    chk("row_ready_load_b", bus.row_ready_o, 1);
    bus.row_data_i = rows[0];
    rst = 1'b1;
    step();
    bus.row_valid_i = 1'b0;
    @(negedge clk);
    check_reset_state();
    chk("reset_writes_left", wq.size(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", bus.cmd_ready_o, 1);
    chk("row_ready_after_reset", bus.row_ready_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
